// File: rtl/pkt_arbiter.sv
// Two-requester packet arbiter feeding one downstream FIFO stream.
// A packet is granted only when the FIFO reports at least MIN_FREE free
// entries; ownership then lasts until the last beat. Packets longer than
// MAX_BEATS are cut with a forced last beat, and the sticky overrun flag is set.
// Optional feature: define PKT_ARBITER_STATS_EN to build the saturating
// per-requester completed-packet counters (otherwise they read as zero).
module pkt_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_EXP  = 8,
  parameter int MIN_FREE   = 64,
  parameter int MAX_BEATS  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s0_tvalid,
  input  logic                  s0_tlast,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  output logic                  s0_tready,
  input  logic                  s1_tvalid,
  input  logic                  s1_tlast,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  output logic                  s1_tready,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  input  logic                  m_tready,
  input  logic [DEPTH_EXP-1:0]  fifo_num_free,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  overrun,
  output logic [15:0]           pkt_cnt0,
  output logic [15:0]           pkt_cnt1
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  // Counter value while the MAX_BEATS-th beat of a packet is on the bus.
  localparam logic [DEPTH_EXP-1:0] LIMIT_IDX  = DEPTH_EXP'(MAX_BEATS - 1);
  localparam logic [31:0]          MIN_FREE_U = 32'(MIN_FREE);

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [DEPTH_EXP-1:0] beat_cnt_q, beat_cnt_d;
  logic                 overrun_q, overrun_d;
  logic                 arm_q;

  logic own0, own1, src_last, at_limit, beat_acc, free_ok;

  // Stream steering: the owner's stream passes straight through, zero latency.
  always_comb begin
    own0      = (state_q == OWN0);
    own1      = (state_q == OWN1);
    m_tvalid  = (own0 & s0_tvalid) | (own1 & s1_tvalid);
    m_tdata   = own0 ? s0_tdata : (own1 ? s1_tdata : '0);
    src_last  = (own0 & s0_tlast) | (own1 & s1_tlast);
    at_limit  = (beat_cnt_q == LIMIT_IDX);
    m_tlast   = src_last | ((own0 | own1) & at_limit);
    s0_tready = own0 & m_tready;
    s1_tready = own1 & m_tready;
    beat_acc  = m_tvalid & m_tready;
    free_ok   = (32'(fifo_num_free) >= MIN_FREE_U);
    grant     = {own1, own0};
    busy      = own0 | own1;
    overrun   = overrun_q;
  end

  // Next-state logic: round-robin grant in IDLE, packet tracking while owned.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    overrun_d    = overrun_q;
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        // arm_q keeps the first edge after reset release grant-free.
        if (arm_q && free_ok) begin
          if (s0_tvalid && (!s1_tvalid || last_grant_q))
            state_d = OWN0;
          else if (s1_tvalid)
            state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (beat_acc) begin
          if (m_tlast) begin
            state_d      = IDLE;
            beat_cnt_d   = '0;
            last_grant_d = own1;
            if (!src_last)
              overrun_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + DEPTH_EXP'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and packet-tracking registers; reset drops any packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      overrun_q    <= 1'b0;
      arm_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      overrun_q    <= overrun_d;
      arm_q        <= 1'b1;
    end
  end

`ifdef PKT_ARBITER_STATS_EN
  logic [15:0] pkt_cnt0_q, pkt_cnt1_q;

  // Completed-packet counters, bumped on every accepted last beat, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt0_q <= 16'd0;
      pkt_cnt1_q <= 16'd0;
    end else if (beat_acc && m_tlast) begin
      if (own0 && (pkt_cnt0_q != 16'hFFFF))
        pkt_cnt0_q <= pkt_cnt0_q + 16'd1;
      if (own1 && (pkt_cnt1_q != 16'hFFFF))
        pkt_cnt1_q <= pkt_cnt1_q + 16'd1;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
`else
  assign pkt_cnt0 = 16'd0;
  assign pkt_cnt1 = 16'd0;
`endif

endmodule
